dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the pipeline MEM stage (port 0) and a DMA/loader engine (port 1). Each cycle it grants at most one requester, drives the memory's address, write-data and write-enable from the winner, registers the read data back to the winner one cycle later, and flags misaligned or out-of-range accesses. It sits between the MEM stage, the DMA engine and the data memory, and gives the hazard unit a stall signal for port 0.

## Interface
- DEPTH, 1024: memory depth in 32-bit words; valid word index is 0..DEPTH-1.
- MAX_BURST, 8: maximum consecutive port-1 beats while locked; range 1..255.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req / p1_req  in  1  access request.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  32  byte address.
- p0_wdata / p1_wdata  in  32  write data.
- p1_lock  in  1  port 1 requests a locked burst.
- p0_gnt / p1_gnt  out  1  combinational grant; the access executes in this cycle.
- p0_rvalid / p1_rvalid  out  1  registered; high for one cycle after a granted read.
- p0_rdata / p1_rdata  out  32  registered read data; holds until the next rvalid for that port.
- p0_err / p1_err  out  1  registered; high for one cycle after a granted access that was misaligned or out of range.
- p0_stall  out  1  p0_req & ~p0_gnt.
- mem_A  out  32  memory address; the winner's address, 0 when there is no grant.
- mem_WD  out  32  memory write data.
- mem_WE  out  1  memory write enable.
- mem_RD  in  32  combinational read data from the memory.

## Operation
- States: ARB and BURST. Registers: last_gnt (1 bit), burst_cnt (8 bits).
- ARB:
  - Only one port requesting: that port wins.
  - Both ports requesting: the winner is chosen per Configuration.
  - If port 1 wins with p1_lock = 1 and MAX_BURST > 1: go to BURST and set burst_cnt = 1.
- BURST:
  - p1_gnt = p1_req & p1_lock, unconditionally. p0 is not granted.
  - Each granted beat increments burst_cnt.
  - Exit to ARB when p1_req = 0, p1_lock = 0, or burst_cnt reaches MAX_BURST after the current beat. The beat that reaches MAX_BURST is granted and is the last beat.
  - In the first ARB cycle after any BURST exit, port 0 wins a conflict regardless of configuration. Locks cannot starve the CPU.
- Access checks:
  - bad = (addr[1:0] != 0) | ((addr >> 2) >= DEPTH).
  - On a bad access: mem_WE is forced to 0, rvalid stays 0, and err pulses next cycle.
  - The grant is still issued, so the requester retires the access.
- Memory drive: mem_WE = winner_we & ~bad. mem_A and mem_WD come from the winner.
- Read return: on a good granted read, mem_RD is captured into that port's rdata at the clock edge, and rvalid is high the next cycle.
- Reset values:
  - gnt = 0 (forced while rst), rvalid = 0, err = 0, rdata = 0.
  - mem_WE = 0, state = ARB, last_gnt = 1 (port 0 preferred first), burst_cnt = 0.
- Reset asserted mid-burst: state returns to ARB the next cycle and no write is issued during the rst cycle.

## Timing
- Grant and memory drive are combinational from req, state and last_gnt in the same cycle. Zero-cycle write.
- Read latency: 1 cycle (gnt in cycle N, rvalid/rdata in cycle N+1).
- Back-to-back grants to the same port are allowed every cycle. Throughput is 1 access per cycle in total.
- Requesters must hold req, we, addr and wdata stable until they see gnt.
- last_gnt updates on every granted cycle. burst_cnt resets to 0 on BURST exit.

## Configuration
- DMEM_ARB_RR_EN defined: on an ARB conflict, the port not granted most recently (the complement of last_gnt) wins. This gives round-robin fairness.
- Not defined: port 0 always wins ARB conflicts (fixed priority). Port 1 is only served when port 0 is idle or while holding a burst.
- BURST behaviour and the post-burst port-0 priority are identical in both builds.

## Test plan
- Reset: hold rst 2 cycles with both ports requesting writes -> no gnt, mem_WE = 0, all rvalid/err = 0. The memory word is unchanged on a later read.
- Single port-0 write then read: write 0xDEADBEEF to 0x10, then read 0x10 -> p0_gnt in both cycles, p0_rvalid the cycle after the read, p0_rdata = 0xDEADBEEF.
- Conflict with DMEM_ARB_RR_EN, both ports reading continuously for 4 cycles -> grants alternate p0, p1, p0, p1. Without the macro -> p0 for all 4 cycles and p0_stall = 0.
- Burst with MAX_BURST = 4: p1 writes 6 words with lock held while p0_req = 1 -> p1 gets 4 consecutive grants, then p0 gets the next cycle. p0_stall is high for the 4 burst cycles.
- Bad address: p0 writes 0x12345678 to 0x13, then to 0x1000 (DEPTH = 1024) -> each is granted, mem_WE = 0, p0_err pulses the following cycle. Reads of 0x10 and 0xFFC are unchanged.
- Reset mid-burst: assert rst in the 2nd beat of a p1 locked burst -> no write that cycle. After release, state is ARB and p0 wins the first conflict.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU MEM stage (port 0) vs DMA/loader (port 1), with locked port-1 bursts.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_lock,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic        p0_err,
    output logic        p1_err,
    output logic        p0_stall,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    typedef enum logic {ARB, BURST} state_e;

    state_e      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic        p0_rvalid_q, p1_rvalid_q;
    logic        p0_err_q, p1_err_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;

    logic        gnt0, gnt1, any_gnt;
    logic        win_we, bad;
    logic [31:0] win_addr, win_wdata;

    // A burst only ever grants port 1, so last_gnt is 1 on every burst exit;
    // that alone gives port 0 the first post-burst conflict in both builds.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB: begin
                    if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
                        gnt0 = last_gnt_q;
                        gnt1 = ~last_gnt_q;
`else
                        gnt0 = 1'b1;
`endif
                    end else begin
                        gnt0 = p0_req;
                        gnt1 = p1_req;
                    end
                    if (gnt1 && p1_lock && (MAX_BURST > 1)) begin
                        state_d     = BURST;
                        burst_cnt_d = 8'd1;
                    end
                end
                BURST: begin
                    gnt1 = p1_req & p1_lock;
                    if (gnt1 && (({1'b0, burst_cnt_q} + 9'd1) < 9'(MAX_BURST))) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end else begin
                        state_d     = ARB;
                        burst_cnt_d = '0;
                    end
                end
                default: state_d = ARB;
            endcase
            if (gnt0 || gnt1) last_gnt_d = gnt1;
        end
    end

    always_comb begin
        any_gnt   = gnt0 | gnt1;
        win_we    = gnt1 ? p1_we    : p0_we;
        win_addr  = gnt1 ? p1_addr  : p0_addr;
        win_wdata = gnt1 ? p1_wdata : p0_wdata;
        bad       = (win_addr[1:0] != 2'b00) | ((win_addr >> 2) >= 32'(DEPTH));
        mem_A     = any_gnt ? win_addr  : '0;
        mem_WD    = any_gnt ? win_wdata : '0;
        mem_WE    = any_gnt & win_we & ~bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            p0_rvalid_q <= gnt0 & ~p0_we & ~bad;
            p1_rvalid_q <= gnt1 & ~p1_we & ~bad;
            p0_err_q    <= gnt0 & bad;
            p1_err_q    <= gnt1 & bad;
            if (gnt0 && !p0_we && !bad) p0_rdata_q <= mem_RD;
            if (gnt1 && !p1_we && !bad) p1_rdata_q <= mem_RD;
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_stall  = p0_req & ~gnt0;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule
